// File: rtl/wr_fram_buf.sv
// wr_fram_buf: width-converting line buffer for the video frame writer.
// Narrow write port (one packed-pixel word per cycle) and wide read port (one DDR beat per
// cycle) built from RD_RATIO narrow banks, so each bank infers a plain block RAM.
// Optional macro WR_FRAM_BUF_OUT_REG_EN adds an output pipeline register (read latency 2).
module wr_fram_buf #(
    parameter int unsigned WR_DATA_WIDTH = 32,
    parameter int unsigned WR_ADDR_WIDTH = 12,
    // Power of two, at least 2.
    parameter int unsigned RD_RATIO      = 4,
    localparam int unsigned RD_DATA_WIDTH = WR_DATA_WIDTH * RD_RATIO,
    localparam int unsigned LANE_W        = $clog2(RD_RATIO),
    localparam int unsigned RD_ADDR_WIDTH = WR_ADDR_WIDTH - LANE_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [WR_DATA_WIDTH-1:0] i_wr_data,
    input  logic [WR_ADDR_WIDTH-1:0] i_wr_addr,
    input  logic                     i_wr_en,
    input  logic [RD_ADDR_WIDTH-1:0] i_rd_addr,
    output logic [RD_DATA_WIDTH-1:0] o_rd_data
);

    localparam int unsigned BANK_DEPTH = 1 << RD_ADDR_WIDTH;

    // Low write-address bits pick the lane (bank); the rest pick the row inside the bank.
    logic [LANE_W-1:0]        w_wr_lane;
    logic [RD_ADDR_WIDTH-1:0] w_wr_row;
    logic                     w_wr_go;
    logic [RD_DATA_WIDTH-1:0] w_rd_word;

    assign w_wr_lane = i_wr_addr[LANE_W-1:0];
    assign w_wr_row  = i_wr_addr[WR_ADDR_WIDTH-1:LANE_W];
    assign w_wr_go   = i_wr_en && !i_rst;

    for (genvar k = 0; k < RD_RATIO; k++) begin : g_bank
        logic [WR_DATA_WIDTH-1:0] r_mem [BANK_DEPTH];
        logic [WR_DATA_WIDTH-1:0] r_rd_lane;
        logic                     w_bank_we;

        assign w_bank_we = w_wr_go && (w_wr_lane == LANE_W'(k));

        // Array write port; no reset so the array maps onto block RAM.
        always_ff @(posedge i_clk) begin
            if (w_bank_we) begin
                r_mem[w_wr_row] <= i_wr_data;
            end
        end

        // Registered read; old contents are returned on a same-edge write (read-first).
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_rd_lane <= '0;
            end else begin
                r_rd_lane <= r_mem[i_rd_addr];
            end
        end

        // Lowest write address lands in the least significant lane.
        assign w_rd_word[k*WR_DATA_WIDTH +: WR_DATA_WIDTH] = r_rd_lane;
    end

`ifdef WR_FRAM_BUF_OUT_REG_EN
    logic [RD_DATA_WIDTH-1:0] r_rd_data_out;

    // Extra output stage to ease timing into the DDR write-data path.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data_out <= '0;
        end else begin
            r_rd_data_out <= w_rd_word;
        end
    end

    assign o_rd_data = r_rd_data_out;
`else
    assign o_rd_data = w_rd_word;
`endif

endmodule

// File: tb/tb_wr_fram_buf.sv
// Scoreboard bench for wr_fram_buf: stimulus pushes expected beats tagged with the clock edge
// after which they must be visible; a negedge monitor pops and compares them.
module tb_wr_fram_buf;

`ifdef WR_FRAM_BUF_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  wr_data;
    logic [11:0]  wr_addr;
    logic         wr_en;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;

    int edge_cnt = 0;
    int total    = 0;
    int bad      = 0;

    int           q_due  [$];
    logic [127:0] q_exp  [$];
    logic [127:0] q_mask [$];
    string        q_name [$];

    localparam logic [127:0] FULL = '1;

    wr_fram_buf dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_data (wr_data),
        .i_wr_addr (wr_addr),
        .i_wr_en   (wr_en),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: compare every expectation that falls due after the latest edge.
    always @(negedge clk) begin
        for (int i = q_due.size() - 1; i >= 0; i--) begin
            if (q_due[i] == edge_cnt) begin
                total++;
                if ((rd_data & q_mask[i]) !== (q_exp[i] & q_mask[i])) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", q_name[i], rd_data & q_mask[i],
                             q_exp[i] & q_mask[i]);
                end
                q_due.delete(i);
                q_exp.delete(i);
                q_mask.delete(i);
                q_name.delete(i);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] fw(int i);
        return {16'(i), 16'(i * 7 + 3)};
    endfunction

    task automatic expect_at(int due, logic [127:0] exp, logic [127:0] mask, string name);
        q_due.push_back(due);
        q_exp.push_back(exp);
        q_mask.push_back(mask);
        q_name.push_back(name);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(int addr, logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = 12'(addr);
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    // Read issued now is sampled at the next edge and visible LAT-1 edges later.
    task automatic rd(int row, logic [127:0] exp, logic [127:0] mask, string name);
        rd_addr = 10'(row);
        expect_at(edge_cnt + LAT, exp, mask, name);
        step();
    endtask

    task automatic rst_cycle(string name);
        rst = 1'b1;
        expect_at(edge_cnt + 1, '0, FULL, name);
        step();
    endtask

    initial begin
        logic [127:0] row0;
        row0    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;

        // Power-up reset: output held at zero.
        rst_cycle("init_rst0");
        rst_cycle("init_rst1");
        rst = 1'b0;

        // Lane packing.
        wr(0, 32'h11111111);
        wr(1, 32'h22222222);
        wr(2, 32'h33333333);
        wr(3, 32'h44444444);
        rd(0, row0, FULL, "lane_pack");

        // Top address; middle lanes never written.
        wr(4095, 32'hDEADBEEF);
        wr(4092, 32'hCAFEF00D);
        rd(1023, {32'hDEADBEEF, 64'h0, 32'hCAFEF00D},
           {32'hFFFFFFFF, 64'h0, 32'hFFFFFFFF}, "top_addr");

        // Write gating by wr_en.
        wr_en   = 1'b0;
        wr_addr = 12'd0;
        wr_data = 32'hFFFFFFFF;
        step();
        rd(0, row0, FULL, "gate_wr_en");

        // Write gating by rst.
        idle(LAT);
        wr_en   = 1'b1;
        wr_addr = 12'd0;
        wr_data = 32'hFFFFFFFF;
        rst_cycle("gate_rst_out");
        rst   = 1'b0;
        wr_en = 1'b0;
        rd(0, row0, FULL, "gate_rst");

        // Reset held two cycles with data present.
        idle(LAT);
        rst_cycle("rst_hold0");
        rst_cycle("rst_hold1");
        rst = 1'b0;
        rd(0, row0, FULL, "rst_release");

        // Read-during-write collision: read-first, new value on next read.
        rd_addr = 10'd0;
        wr_en   = 1'b1;
        wr_addr = 12'd1;
        wr_data = 32'hAAAAAAAA;
        expect_at(edge_cnt + LAT, row0, FULL, "collide_old");
        step();
        wr_en = 1'b0;
        rd(0, {32'h44444444, 32'h33333333, 32'hAAAAAAAA, 32'h11111111}, FULL, "collide_new");

        // Streaming: one 640-word line, then back-to-back wide reads.
        for (int i = 0; i < 640; i++) wr(i, fw(i));
        for (int r = 0; r < 160; r++) begin
            rd(r, {fw(4*r+3), fw(4*r+2), fw(4*r+1), fw(4*r)}, FULL, $sformatf("stream_%0d", r));
        end

        idle(LAT + 2);
        total++;
        if (q_due.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q_due.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
